// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the keyboard clock,
// shifts in 11-bit frames (start, 8 data LSB-first, odd parity, stop) and
// reports good scan codes plus a two-code history for the hex display.
module ps2_rx #(
  parameter int FILT    = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [7:0]  code,
  output logic        code_valid,
  output logic        frame_err,
  output logic [15:0] hex,
  output logic        busy
);

  localparam int FCW = $clog2(FILT + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           strobe_q, strobe_d;
  state_t         state_q, state_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [7:0]     code_q, code_d;
  logic [15:0]    hex_q, hex_d;
  logic           cv_q, cv_d;
  logic           err_q, err_d;

  // Two-flop synchronizers; idle lines are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: flip the level after FILT consecutive differing samples;
  // a flip from 1 to 0 is the bit strobe.
  always_comb begin
    filt_d   = filt_q;
    fcnt_d   = '0;
    strobe_d = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCW'(FILT - 1)) begin
        filt_d   = ~filt_q;
        strobe_d = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Filter level, filter run counter and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      strobe_q <= strobe_d;
    end
  end

  // Frame FSM next state, inter-strobe timeout and result outputs.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    code_d  = code_q;
    hex_d   = hex_q;
    cv_d    = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE || strobe_q) tmo_d = '0;
    else                             tmo_d = tmo_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (strobe_q && !dat_s2_q) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (strobe_q) begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (strobe_q) begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (strobe_q) begin
          if (dat_s2_q && (^{shift_q, par_q})) begin
            code_d = shift_q;
            hex_d  = {hex_q[7:0], shift_q};
            cv_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe in the terminal cycle wins, so only time out without one.
    if (state_q != IDLE && !strobe_q && tmo_q == TCW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  // FSM, shift register, timeout counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      code_q  <= '0;
      hex_q   <= '0;
      cv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      hex_q   <= hex_d;
      cv_q    <= cv_d;
      err_q   <= err_d;
    end
  end

  assign code       = code_q;
  assign hex        = hex_q;
  assign code_valid = cv_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good frames, bad parity/stop, timeout,
// clock glitch rejection and mid-frame reset.
module tb_ps2_rx;
  localparam int FILT    = 4;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [7:0]  code;
  logic        code_valid;
  logic        frame_err;
  logic [15:0] hex;
  logic        busy;

  ps2_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .code_valid(code_valid), .frame_err(frame_err),
    .hex(hex), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int cv_cnt = 0, err_cnt = 0, cv_cyc = 0, both_cnt = 0;
  int nvec = 0, nmis = 0;
  int last_fall = 0;

  // Free-running edge counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor on the falling edge.
  always @(negedge clk) begin
    if (code_valid) begin
      cv_cnt <= cv_cnt + 1;
      cv_cyc <= cyc;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (code_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    last_fall = cyc;
    tick(20);
    ps2_clk = 1'b1;
    tick(20);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    ps2_data = 1'b1;
    tick(10);
  endtask

  task automatic test_reset();
    tick(3);
    nvec++; if (code !== 8'h00) begin nmis++; $display("FAIL reset_code: got %h want 00", code); end
    nvec++; if (hex !== 16'h0000) begin nmis++; $display("FAIL reset_hex: got %h want 0000", hex); end
    nvec++; if (code_valid !== 1'b0) begin nmis++; $display("FAIL reset_cv: got %b want 0", code_valid); end
    nvec++; if (frame_err !== 1'b0) begin nmis++; $display("FAIL reset_err: got %b want 0", frame_err); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_good_frame();
    int cv0, e0, lat;
    cv0 = cv_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    lat = cv_cyc - last_fall;
    nvec++; if (cv_cnt - cv0 !== 1) begin nmis++; $display("FAIL good_cv_pulses: got %0d want 1", cv_cnt - cv0); end
    nvec++; if (err_cnt - e0 !== 0) begin nmis++; $display("FAIL good_err_pulses: got %0d want 0", err_cnt - e0); end
    nvec++; if (code !== 8'h1C) begin nmis++; $display("FAIL good_code: got %h want 1c", code); end
    nvec++; if (hex !== 16'h001C) begin nmis++; $display("FAIL good_hex: got %h want 001c", hex); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL good_busy: got %b want 0", busy); end
    nvec++; if (lat < 1 || lat > FILT + 4) begin nmis++; $display("FAIL good_latency: got %0d want 1..%0d", lat, FILT + 4); end
  endtask

  task automatic test_second_frame();
    int cv0;
    cv0 = cv_cnt;
    send_frame(8'hF0, 1'b1, 1'b1);
    nvec++; if (cv_cnt - cv0 !== 1) begin nmis++; $display("FAIL second_cv_pulses: got %0d want 1", cv_cnt - cv0); end
    nvec++; if (code !== 8'hF0) begin nmis++; $display("FAIL second_code: got %h want f0", code); end
    nvec++; if (hex !== 16'h1CF0) begin nmis++; $display("FAIL second_hex: got %h want 1cf0", hex); end
  endtask

  task automatic test_bad_frames();
    int cv0, e0;
    cv0 = cv_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    nvec++; if (err_cnt - e0 !== 1) begin nmis++; $display("FAIL parity_err_pulses: got %0d want 1", err_cnt - e0); end
    nvec++; if (cv_cnt - cv0 !== 0) begin nmis++; $display("FAIL parity_cv_pulses: got %0d want 0", cv_cnt - cv0); end
    nvec++; if (hex !== 16'h1CF0) begin nmis++; $display("FAIL parity_hex: got %h want 1cf0", hex); end
    nvec++; if (code !== 8'hF0) begin nmis++; $display("FAIL parity_code: got %h want f0", code); end
    cv0 = cv_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    nvec++; if (err_cnt - e0 !== 1) begin nmis++; $display("FAIL stop_err_pulses: got %0d want 1", err_cnt - e0); end
    nvec++; if (cv_cnt - cv0 !== 0) begin nmis++; $display("FAIL stop_cv_pulses: got %0d want 0", cv_cnt - cv0); end
    nvec++; if (hex !== 16'h1CF0) begin nmis++; $display("FAIL stop_hex: got %h want 1cf0", hex); end
    nvec++; if (code !== 8'hF0) begin nmis++; $display("FAIL stop_code: got %h want f0", code); end
  endtask

  task automatic test_glitch();
    int cv0, e0, busy_seen;
    cv0 = cv_cnt; e0 = err_cnt; busy_seen = 0;
    ps2_data = 1'b0;
    tick(5);
    ps2_clk = 1'b0;
    tick(FILT - 1);
    ps2_clk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0) busy_seen++;
      tick(1);
    end
    ps2_data = 1'b1;
    tick(5);
    nvec++; if (busy_seen !== 0) begin nmis++; $display("FAIL glitch_busy: got %0d busy cycles want 0", busy_seen); end
    nvec++; if ((cv_cnt - cv0) + (err_cnt - e0) !== 0) begin nmis++; $display("FAIL glitch_pulses: got %0d want 0", (cv_cnt - cv0) + (err_cnt - e0)); end
  endtask

  task automatic test_timeout();
    int got;
    got = -1;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    nvec++; if (busy !== 1'b1) begin nmis++; $display("FAIL timeout_busy_before: got %b want 1", busy); end
    for (int i = 0; i < TIMEOUT + 100; i++) begin
      tick(1);
      if (frame_err === 1'b1) begin
        got = cyc - last_fall;
        break;
      end
    end
    nvec++; if (got !== FILT + 3 + TIMEOUT) begin nmis++; $display("FAIL timeout_delay: got %0d want %0d", got, FILT + 3 + TIMEOUT); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL timeout_busy_after: got %b want 0", busy); end
    ps2_data = 1'b1;
    tick(10);
    send_frame(8'h1C, 1'b0, 1'b1);
    nvec++; if (code !== 8'h1C) begin nmis++; $display("FAIL timeout_next_code: got %h want 1c", code); end
    nvec++; if (hex !== 16'hF01C) begin nmis++; $display("FAIL timeout_next_hex: got %h want f01c", hex); end
  endtask

  task automatic test_reset_midframe();
    int e0, cv0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    nvec++; if (busy !== 1'b1) begin nmis++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    e0 = err_cnt;
    rst_n = 1'b0;
    #2;
    nvec++; if ({code, hex, code_valid, frame_err, busy} !== 27'd0) begin
      nmis++; $display("FAIL midrst_outputs: got code=%h hex=%h cv=%b err=%b busy=%b want all 0", code, hex, code_valid, frame_err, busy);
    end
    tick(5);
    rst_n = 1'b1;
    ps2_data = 1'b1;
    tick(10);
    nvec++; if (err_cnt - e0 !== 0) begin nmis++; $display("FAIL midrst_err_pulses: got %0d want 0", err_cnt - e0); end
    cv0 = cv_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    nvec++; if (cv_cnt - cv0 !== 1) begin nmis++; $display("FAIL midrst_cv_pulses: got %0d want 1", cv_cnt - cv0); end
    nvec++; if (code !== 8'h1C) begin nmis++; $display("FAIL midrst_code: got %h want 1c", code); end
    nvec++; if (hex !== 16'h001C) begin nmis++; $display("FAIL midrst_hex: got %h want 001c", hex); end
  endtask

  task automatic test_exclusive();
    nvec++; if (both_cnt !== 0) begin nmis++; $display("FAIL cv_err_overlap: got %0d cycles want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_second_frame();
    test_bad_frames();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILT, default 4: number of consecutive equal synchronized ps2_clk samples needed to change its filtered level.
REQ-002 SHALL have parameter TIMEOUT, default 100000: clk cycles allowed between bit strobes inside a frame (1 ms at 100 MHz).
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: keyboard clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: keyboard data line, asynchronous to clk.
REQ-007 SHALL have port code, output, 8 bits: last correctly received scan code.
REQ-008 SHALL have port code_valid, output, 1 bit: one-cycle pulse when code updates.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a rejected frame.
REQ-010 SHALL have port hex, output, 16 bits: two most recent good codes, {previous, latest}, which drives the display stage's hex input.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-012 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any other use.
REQ-013 SHALL change the filtered ps2_clk level only after FILT consecutive synchronized samples differ from it; shorter glitches are ignored.
REQ-014 SHALL generate a bit strobe for one cycle on each 1-to-0 transition of the filtered ps2_clk and sample synchronized ps2_data in that cycle.
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY and STOP.
REQ-016 IDLE: strobe with data=0 -> DATA, bit count=0; strobe with data=1 -> stay in IDLE, no error.
REQ-017 DATA: each strobe shifts data into the byte LSB-first; the 8th strobe -> PARITY.
REQ-018 PARITY: strobe captures the parity bit -> STOP.
REQ-019 STOP: on strobe, if stop bit=1 and data plus parity has an odd number of ones, the FSM SHALL set code=byte, set hex={hex[7:0],byte} and pulse code_valid in the following cycle.
REQ-020 STOP: on strobe with a bad parity or stop bit=0, the FSM SHALL pulse frame_err and leave code and hex unchanged.
REQ-021 STOP SHALL return to IDLE on the strobe in both the good and the bad case.
REQ-022 SHALL count clk cycles since the last strobe while not in IDLE; on reaching TIMEOUT it SHALL discard the partial frame, pulse frame_err and go to IDLE.
REQ-023 If a strobe and the timeout terminal count occur in the same cycle, the strobe SHALL win and the counter SHALL clear.
REQ-024 busy SHALL be high exactly when the FSM is not in IDLE.
REQ-025 code_valid SHALL rise no more than FILT+4 clk cycles after the raw ps2_clk falling edge of the stop bit.
REQ-026 code_valid and frame_err SHALL never be high in the same cycle.
REQ-027 The block SHALL be receive-only and SHALL never drive ps2_clk or ps2_data.

Reset
REQ-028 While rst_n=0, the block SHALL hold code=0, hex=0, code_valid=0, frame_err=0, busy=0, the FSM in IDLE, and all counters, synchronizers and the filter at their idle values (filtered clk=1).
REQ-029 Reset asserted mid-frame SHALL discard the frame without pulsing frame_err; after release the first strobe is treated as a start bit.

Verification
REQ-030 Bench SHALL cover: frame 0x1C with parity=0 and stop=1 -> code=0x1C, one code_valid pulse, hex=0x001C.
REQ-031 Bench SHALL cover: frame 0xF0 with parity=1 following the 0x1C frame -> hex=0x1CF0, code=0xF0.
REQ-032 Bench SHALL cover: frame 0x1C with parity=1 -> one frame_err pulse, no code_valid, hex unchanged; the same with stop=0 -> same response.
REQ-033 Bench SHALL cover: 5 bits then ps2_clk stops high -> frame_err exactly TIMEOUT cycles after the last strobe, busy falls; a following valid 0x1C frame decodes correctly.
REQ-034 Bench SHALL cover: ps2_clk low pulse of FILT-1 cycles while IDLE with data=0 -> no strobe, busy stays 0.
REQ-035 Bench SHALL cover: rst_n pulsed low after the 4th data bit -> all outputs 0, no frame_err; a following valid frame decodes correctly.
